// File: rtl/uop_issue_queue_if.sv
// ---------------------------------------------------------------------------
// riscv_uop_pkg + uop_issue_queue_if
//
// Purpose:
//   riscv_uop_pkg defines the micro-op record that moves from decode to
//   execute/LSU. The queue only looks at the .valid field. All other fields
//   are carried through unchanged.
//
//   uop_issue_queue_if groups the enqueue, dequeue and status signals of the
//   issue queue. Signal suffixes are written from the queue's point of view.
//
// Signals:
//   flush_i        discard all stored and arriving uops
//   enq_valid_i    per-lane enqueue request (ENQ_W)
//   enq_uop_i      per-lane uop, lane 0 oldest (ENQ_W x uop_t)
//   enq_ready_o    queue can take ENQ_W uops this cycle
//   deq_valid_o    deq_uop_o holds the oldest uop
//   deq_uop_o      oldest uop
//   deq_ready_i    consumer accepts deq_uop_o
//   count_o        stored entries
//   almost_full_o  count_o at or above the almost-full threshold
//
// Modports:
//   master  producer/consumer side (decode + execute)
//   slave   queue side
// ---------------------------------------------------------------------------
package riscv_uop_pkg;

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
  } uop_t;

endpackage

interface uop_issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                                 flush_i;
  logic [ENQ_W-1:0]                     enq_valid_i;
  riscv_uop_pkg::uop_t [ENQ_W-1:0]      enq_uop_i;
  logic                                 enq_ready_o;
  logic                                 deq_valid_o;
  riscv_uop_pkg::uop_t                  deq_uop_o;
  logic                                 deq_ready_i;
  logic [CNT_W-1:0]                     count_o;
  logic                                 almost_full_o;

  modport master (
    output flush_i, enq_valid_i, enq_uop_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_uop_o, count_o, almost_full_o
  );

  modport slave (
    input  flush_i, enq_valid_i, enq_uop_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_uop_o, count_o, almost_full_o
  );

endinterface

// File: rtl/uop_issue_queue.sv
// ---------------------------------------------------------------------------
// uop_issue_queue
//
// Purpose:
//   This is a multi-entry micro-op buffer that sits between decode and
//   execute/LSU. Each cycle it accepts up to ENQ_W uops. Live lanes are
//   packed into consecutive slots, so lanes that are not live take no slot.
//   The queue sends out one uop per cycle, in program order.
//   A flush clears the queue in one cycle. When BYPASS is set and the queue
//   is empty, the oldest arriving uop can be dispatched in the same cycle
//   it arrives.
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    uop_issue_queue_if.slave (enqueue lanes, dequeue port, flush,
//          count_o, almost_full_o)
//
// Parameters:
//   DEPTH         entries, power of two, >= 2, >= ENQ_W
//   ENQ_W         enqueue lanes per cycle, 1..4
//   AFULL_THRESH  almost_full_o asserts when count_o >= this value
//   BYPASS        1 = an empty-queue uop may dispatch in its arrival cycle
// ---------------------------------------------------------------------------

// Protocol checker: live enqueue lanes must only appear while the queue is ready.
module uop_issue_queue_chk #(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic [ENQ_W-1:0] live_i,
  input logic             enq_ready_i,
  input logic [CNT_W-1:0] count_i
);
  // A live lane while not ready is dropped by the queue; flag it.
  enq_live_while_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    !((|live_i) && !enq_ready_i))
    else $error("uop_issue_queue: live enqueue lane while enq_ready_o=0");

  // Occupancy can never exceed the storage size.
  count_bound_a : assert property (@(posedge clk) disable iff (!rst_n)
    count_i <= CNT_W'(DEPTH))
    else $error("uop_issue_queue: count_o above DEPTH");
endmodule

module uop_issue_queue #(
  parameter int DEPTH        = 8,
  parameter int ENQ_W        = 2,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int BYPASS       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uop_issue_queue_if.slave       bus
);
  import riscv_uop_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ENQW_C  = CNT_W'(ENQ_W);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);

  uop_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_ready_q, enq_ready_d;
  logic             almost_full_q, almost_full_d;

  logic [ENQ_W-1:0] live_s;        // lane carries a real uop
  logic [ENQ_W-1:0] acc_s;         // live and accepted this cycle
  logic [ENQ_W-1:0] byp_onehot_s;  // lowest accepted lane
  logic [ENQ_W-1:0] wr_en_s;       // lanes that take a storage slot
  logic [PTR_W-1:0] wr_idx_s [ENQ_W];
  logic [PTR_W-1:0] wr_adv_s;
  logic [CNT_W-1:0] n_wr_s;
  uop_t             byp_uop_s;
  logic             byp_hit_s;
  logic             byp_take_s;
  logic             stored_s;
  logic             deq_valid_s;
  logic             mem_fire_s;
  uop_t             deq_uop_s;

  // Lane qualification and bypass candidate selection.
  always_comb begin
    for (int k = 0; k < ENQ_W; k++) begin
      live_s[k] = bus.enq_valid_i[k] & bus.enq_uop_i[k].valid;
    end
    // Flush and "not ready" both drop arriving lanes outright.
    acc_s        = live_s & {ENQ_W{enq_ready_q & ~bus.flush_i}};
    // Isolate the lowest set bit: that lane is the oldest arrival.
    byp_onehot_s = acc_s & (~acc_s + ENQ_W'(1));
    byp_uop_s    = '0;
    for (int k = 0; k < ENQ_W; k++) begin
      byp_uop_s = byp_uop_s | (byp_onehot_s[k] ? bus.enq_uop_i[k] : '0);
    end
  end

  // Dequeue port: stored head first, otherwise the bypass candidate.
  always_comb begin
    stored_s    = (count_q != '0);
    byp_hit_s   = (BYPASS != 0) && !stored_s && (|acc_s);
    deq_valid_s = !bus.flush_i && (stored_s || byp_hit_s);
    deq_uop_s   = stored_s ? mem_q[rd_ptr_q] : byp_uop_s;
    mem_fire_s  = deq_valid_s && bus.deq_ready_i && stored_s;
    byp_take_s  = byp_hit_s && bus.deq_ready_i;
  end

  // Compaction: accepted lanes (minus a consumed bypass lane) get consecutive slots.
  always_comb begin
    wr_en_s  = acc_s & ~(byp_take_s ? byp_onehot_s : '0);
    wr_adv_s = '0;
    n_wr_s   = '0;
    for (int k = 0; k < ENQ_W; k++) begin
      wr_idx_s[k] = wr_ptr_q + wr_adv_s;
      wr_adv_s    = wr_adv_s + PTR_W'(wr_en_s[k]);
      n_wr_s      = n_wr_s + CNT_W'(wr_en_s[k]);
    end
  end

  // Next-state pointers, count and registered status flags.
  always_comb begin
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + wr_adv_s;
      rd_ptr_d = rd_ptr_q + PTR_W'(mem_fire_s);
      count_d  = count_q + n_wr_s - CNT_W'(mem_fire_s);
    end
    enq_ready_d   = (DEPTH_C - count_d) >= ENQW_C;
    almost_full_d = count_d >= AFULL_C;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      enq_ready_q   <= 1'b1;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      enq_ready_q   <= enq_ready_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_W; k++) begin
      if (wr_en_s[k]) begin
        mem_q[wr_idx_s[k]] <= bus.enq_uop_i[k];
      end
    end
  end

  assign bus.enq_ready_o   = enq_ready_q;
  assign bus.deq_valid_o   = deq_valid_s;
  assign bus.deq_uop_o     = deq_uop_s;
  assign bus.count_o       = count_q;
  assign bus.almost_full_o = almost_full_q;

  uop_issue_queue_chk #(
    .DEPTH (DEPTH),
    .ENQ_W (ENQ_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .live_i      (live_s),
    .enq_ready_i (enq_ready_q),
    .count_i     (count_q)
  );

endmodule

// File: tb/tb_uop_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_uop_issue_queue
//
// Bench for uop_issue_queue. It drives two instances, one with BYPASS=0 and
// one with BYPASS=1, from the same stimulus. Each instance is checked
// against its own queue-based reference model.
// ---------------------------------------------------------------------------
module tb_uop_issue_queue;
  import riscv_uop_pkg::*;

  localparam int DEPTH = 8;
  localparam int ENQ_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush;
  logic [ENQ_W-1:0]  ev;
  uop_t [ENQ_W-1:0]  eu;
  logic              dr;

  uop_issue_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W)) bus0 ();
  uop_issue_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W)) bus1 ();

  assign bus0.flush_i     = flush;
  assign bus0.enq_valid_i = ev;
  assign bus0.enq_uop_i   = eu;
  assign bus0.deq_ready_i = dr;
  assign bus1.flush_i     = flush;
  assign bus1.enq_valid_i = ev;
  assign bus1.enq_uop_i   = eu;
  assign bus1.deq_ready_i = dr;

  uop_issue_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .AFULL_THRESH(DEPTH-2), .BYPASS(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  uop_issue_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .AFULL_THRESH(DEPTH-2), .BYPASS(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  uop_t q0[$];
  uop_t q1[$];
  logic [31:0] log0[$];
  logic [31:0] log1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic uop_t mk(input logic [4:0] rd, input logic [31:0] imm);
    uop_t u;
    u.valid  = 1'b1;
    u.opcode = 7'($urandom);
    u.rd     = rd;
    u.rs1    = 5'($urandom);
    u.imm    = imm;
    return u;
  endfunction

  task automatic idle();
    flush = 1'b0;
    ev    = '0;
    eu    = '0;
    dr    = 1'b0;
  endtask

  // Reference: a plain FIFO of uops. Checks one instance, then applies this cycle's events.
  task automatic model_step(input bit byp, input string tag, inout uop_t mq[$],
                            input logic o_dv, input uop_t o_u, input logic o_rdy,
                            input logic [3:0] o_cnt, input logic o_af,
                            output bit fired, output uop_t fu);
    uop_t lanes[$];
    bit   rdy;
    bit   exp_dv;
    fired = 1'b0;
    fu    = '0;
    rdy   = (DEPTH - mq.size()) >= ENQ_W;
    chk({tag, ".count"}, 64'(o_cnt), 64'(mq.size()));
    chk({tag, ".enq_ready"}, 64'(o_rdy), 64'(rdy));
    chk({tag, ".almost_full"}, 64'(o_af), 64'(mq.size() >= DEPTH - 2));
    if (!flush && rdy) begin
      for (int k = 0; k < ENQ_W; k++) begin
        if (ev[k] && eu[k].valid) lanes.push_back(eu[k]);
      end
    end
    exp_dv = !flush && (mq.size() != 0 || (byp && lanes.size() != 0));
    chk({tag, ".deq_valid"}, 64'(o_dv), 64'(exp_dv));
    if (exp_dv) chk({tag, ".deq_uop"}, 64'(o_u), 64'((mq.size() != 0) ? mq[0] : lanes[0]));
    if (flush) begin
      mq.delete();
    end else begin
      if (exp_dv && dr) begin
        fired = 1'b1;
        if (mq.size() != 0) fu = mq.pop_front();
        else fu = lanes.pop_front();
      end
      foreach (lanes[i]) mq.push_back(lanes[i]);
    end
  endtask

  // One clock: check both instances mid-cycle, then advance past the edge.
  task automatic step();
    bit   f0, f1;
    uop_t u0, u1;
    @(negedge clk);
    model_step(1'b0, "b0", q0, bus0.deq_valid_o, bus0.deq_uop_o, bus0.enq_ready_o,
               bus0.count_o, bus0.almost_full_o, f0, u0);
    model_step(1'b1, "b1", q1, bus1.deq_valid_o, bus1.deq_uop_o, bus1.enq_ready_o,
               bus1.count_o, bus1.almost_full_o, f1, u1);
    if (f0) log0.push_back(u0.imm);
    if (f1) log1.push_back(u1.imm);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    idle();
    dr = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      step();
      n++;
    end
    chk({tag, ".drain_in_budget"}, 64'(n < 40), 64'(1));
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_imm;
    int cyc;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();  // reset state: count 0, ready 1, nothing valid

    // T1: reset asserted mid-traffic with 5 entries stored
    ev = 2'b11;
    eu[0] = mk(5'd1, 32'd100); eu[1] = mk(5'd2, 32'd101); step();
    eu[0] = mk(5'd3, 32'd102); eu[1] = mk(5'd4, 32'd103); step();
    ev = 2'b01;
    eu[0] = mk(5'd5, 32'd104); eu[1] = '0; step();
    idle();
    chk("t1.pre_count", 64'(bus0.count_o), 64'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("t1.count", 64'(bus0.count_o), 64'(0));
    chk("t1.deq_valid", 64'(bus0.deq_valid_o), 64'(0));
    chk("t1.enq_ready", 64'(bus0.enq_ready_o), 64'(1));
    chk("t1.b1.count", 64'(bus1.count_o), 64'(0));
    q0.delete(); q1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // T2: fill with two live lanes per cycle and no dequeue
    for (int c = 0; c < 4; c++) begin
      ev = 2'b11;
      eu[0] = mk(5'(c), 32'(200 + 2 * c));
      eu[1] = mk(5'(c), 32'(201 + 2 * c));
      step();
    end
    idle();
    chk("t2.enq_ready_full", 64'(bus0.enq_ready_o), 64'(0));
    chk("t2.count_full", 64'(bus0.count_o), 64'(8));
    chk("t2.almost_full", 64'(bus0.almost_full_o), 64'(1));
    step();
    drain("t2");

    // T3: lane 0 requests but carries an invalid uop; lane 1 is live with rd=5
    ev = 2'b11;
    eu[0] = mk(5'd9, 32'd300); eu[0].valid = 1'b0;
    eu[1] = mk(5'd5, 32'd301);
    step();
    idle();
    chk("t3.count_one", 64'(bus0.count_o), 64'(1));
    chk("t3.rd", 64'(bus0.deq_uop_o.rd), 64'(5));
    dr = 1'b1;
    step();
    idle();
    chk("t3.count_zero", 64'(bus0.count_o), 64'(0));
    step();

    // T4: 20 uops, random lane gaps and random deq_ready, across pointer wrap
    log0.delete(); log1.delete();
    next_imm = 0;
    cyc = 0;
    while ((next_imm < 20 || q0.size() != 0 || q1.size() != 0) && cyc < 400) begin
      idle();
      dr = 1'($urandom_range(0, 1));
      if ((DEPTH - q0.size()) >= ENQ_W && (DEPTH - q1.size()) >= ENQ_W) begin
        for (int k = 0; k < ENQ_W; k++) begin
          if (next_imm < 20 && $urandom_range(0, 2) != 0) begin
            ev[k] = 1'b1;
            eu[k] = mk(5'(k), 32'(next_imm));
            next_imm++;
          end else if ($urandom_range(0, 1) == 1) begin
            ev[k] = 1'b1;
            eu[k] = mk(5'(k), 32'hDEAD);
            eu[k].valid = 1'b0;
          end
        end
      end
      step();
      cyc++;
    end
    idle();
    chk("t4.in_budget", 64'(cyc < 400), 64'(1));
    chk("t4.b0.n_out", 64'(log0.size()), 64'(20));
    chk("t4.b1.n_out", 64'(log1.size()), 64'(20));
    for (int i = 0; i < 20; i++) begin
      if (i < log0.size()) chk("t4.b0.order", 64'(log0[i]), 64'(i));
      if (i < log1.size()) chk("t4.b1.order", 64'(log1[i]), 64'(i));
    end

    // T5: flush with 6 stored and 2 arriving, consumer ready
    for (int c = 0; c < 3; c++) begin
      ev = 2'b11;
      eu[0] = mk(5'd1, 32'(400 + 2 * c));
      eu[1] = mk(5'd2, 32'(401 + 2 * c));
      step();
    end
    flush = 1'b1; ev = 2'b11; dr = 1'b1;
    eu[0] = mk(5'd3, 32'd500); eu[1] = mk(5'd4, 32'd501);
    #1;
    chk("t5.no_deq", 64'(bus0.deq_valid_o), 64'(0));
    step();
    idle();
    dr = 1'b1;
    chk("t5.count", 64'(bus0.count_o), 64'(0));
    chk("t5.deq_valid", 64'(bus0.deq_valid_o), 64'(0));
    step();

    // T6: empty queue, lane 0 imm=0xAA, consumer ready
    idle();
    ev = 2'b01; dr = 1'b1;
    eu[0] = mk(5'd7, 32'h000000AA);
    #1;
    chk("t6.byp.valid", 64'(bus1.deq_valid_o), 64'(1));
    chk("t6.byp.imm", 64'(bus1.deq_uop_o.imm), 64'h00000000_000000AA);
    chk("t6.nobyp.valid", 64'(bus0.deq_valid_o), 64'(0));
    step();
    idle();
    dr = 1'b1;
    #1;
    chk("t6.byp.count", 64'(bus1.count_o), 64'(0));
    chk("t6.nobyp.valid_late", 64'(bus0.deq_valid_o), 64'(1));
    chk("t6.nobyp.imm", 64'(bus0.deq_uop_o.imm), 64'h00000000_000000AA);
    step();
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
